register_bank_sb: RTL and testbench

Parametrised successor to the 8×8 register bank: DEPTH×WIDTH register file with two asynchronous read ports, one synchronous write port, optional write-to-read bypass, optional hardwired-zero R0, and a per-register busy scoreboard for multi-cycle producers. It sits between decode (read and reserve) and writeback (write and release), and gives the controller the hazard information needed to stall.

---
 rtl/register_bank_sb_pkg.sv | 14 +
 rtl/register_bank_sb_reg_scoreboard.sv | 69 ++++++
 rtl/register_bank_sb.sv | 75 +++++++
 tb/tb_register_bank_sb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_sb_pkg.sv
// Shared definitions for the scoreboarded register bank: address-width helper,
// reset value and the default busy-vector type.
package register_bank_sb_pkg;

  localparam bit RST_VAL   = 1'b0;
  localparam int DEF_DEPTH = 8;

  typedef logic [DEF_DEPTH-1:0] busyVec_t;

  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register_bank_sb_reg_scoreboard.sv
// Per-register busy tracking: reservation ack, release on writeback, pending count.
// Zero latency on ack and busy reads; busy/count update on the clock edge.
module reg_scoreboard
  import register_bank_sb_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = addrWidth(DEPTH),
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] destAddr,
  input  logic          writeBack,
  input  logic          reserve,
  input  logic [AW-1:0] resvAddr,
  output logic          busy1,
  output logic          busy2,
  output logic          resvAck,
  output logic [AW:0]   pendCnt
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic [DEPTH-1:0] relVec;
  logic [DEPTH-1:0] setVec;
  logic [DEPTH-1:0] liveMask;
  logic             setsBit;
  logic             clearsBit;

  always_comb begin
    liveMask = '1;
    if (ZERO_R0) liveMask[0] = 1'b0;

    relVec = '0;
    if (writeBack) relVec[destAddr] = 1'b1;
    relVec = relVec & liveMask;

    // A register being released this cycle can be re-reserved immediately.
    resvAck = reserve & (~busy[resvAddr] | (writeBack & (destAddr == resvAddr)));

    setVec = '0;
    if (resvAck) setVec[resvAddr] = 1'b1;
    setVec = setVec & liveMask;

    busyNext  = (busy & ~relVec) | setVec;
    setsBit   = |(setVec & ~busy);
    clearsBit = |(relVec & busy & ~setVec);

    busy1 = busy[addr1] & ~(BYPASS & relVec[addr1]);
    busy2 = busy[addr2] & ~(BYPASS & relVec[addr2]);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy    <= {DEPTH{RST_VAL}};
      pendCnt <= {(AW+1){RST_VAL}};
    end else begin
      busy <= busyNext;
      if (setsBit && !clearsBit)
        pendCnt <= pendCnt + (AW+1)'(1);
      else if (clearsBit && !setsBit)
        pendCnt <= pendCnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/register_bank_sb.sv
// DEPTH x WIDTH register file with two async read ports, one sync write port,
// optional writeback bypass, optional hardwired-zero R0 and a busy scoreboard.
module register_bank_sb
  import register_bank_sb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0,
  parameter int AW      = addrWidth(DEPTH)
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic [AW-1:0]    i_AddrReg1,
  input  logic [AW-1:0]    i_AddrReg2,
  output logic [WIDTH-1:0] o_Data1,
  output logic [WIDTH-1:0] o_Data2,
  output logic             o_Busy1,
  output logic             o_Busy2,
  input  logic [AW-1:0]    i_AddrRegDest,
  input  logic [WIDTH-1:0] i_WriteData,
  input  logic             i_WriteBack,
  input  logic             i_Reserve,
  input  logic [AW-1:0]    i_AddrResv,
  output logic             o_ResvAck,
  output logic [AW:0]      o_PendCnt
);

  logic [WIDTH-1:0] regFile [DEPTH];
  logic             wrEn;
  logic             fwdEn;

  assign wrEn  = i_WriteBack && !(ZERO_R0 && (i_AddrRegDest == '0));
  // Forwarding is suppressed in reset so outputs show the cleared state.
  assign fwdEn = BYPASS && i_RSTn && i_WriteBack;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < DEPTH; i++) regFile[i] <= {WIDTH{RST_VAL}};
    end else if (wrEn) begin
      regFile[i_AddrRegDest] <= i_WriteData;
    end
  end

  always_comb begin
    o_Data1 = regFile[i_AddrReg1];
    if (fwdEn && (i_AddrRegDest == i_AddrReg1)) o_Data1 = i_WriteData;
    if (ZERO_R0 && (i_AddrReg1 == '0)) o_Data1 = '0;

    o_Data2 = regFile[i_AddrReg2];
    if (fwdEn && (i_AddrRegDest == i_AddrReg2)) o_Data2 = i_WriteData;
    if (ZERO_R0 && (i_AddrReg2 == '0)) o_Data2 = '0;
  end

  reg_scoreboard #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .BYPASS (BYPASS),
    .ZERO_R0(ZERO_R0)
  ) u_scoreboard (
    .clk      (i_CLK),
    .rstN     (i_RSTn),
    .addr1    (i_AddrReg1),
    .addr2    (i_AddrReg2),
    .destAddr (i_AddrRegDest),
    .writeBack(i_WriteBack),
    .reserve  (i_Reserve),
    .resvAddr (i_AddrResv),
    .busy1    (o_Busy1),
    .busy2    (o_Busy2),
    .resvAck  (o_ResvAck),
    .pendCnt  (o_PendCnt)
  );

endmodule

// File: tb/tb_register_bank_sb.sv
// Three configurations (bypass, no bypass, bypass+zero R0) driven with shared stimulus
// and checked against an array/queue-level model of register and reservation rules.
module tb_register_bank_sb;
  import register_bank_sb_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] addr1, addr2, dest, resvA;
  logic [7:0] wd;
  logic       wb, reserve;

  logic [7:0] data1 [3];
  logic [7:0] data2 [3];
  logic       busy1 [3];
  logic       busy2 [3];
  logic       ack   [3];
  logic [3:0] pend  [3];

  int checks = 0;
  int failures = 0;

  bit         cfgByp  [3];
  bit         cfgZero [3];
  logic [7:0] mReg  [3][8];
  busyVec_t   mBusy [3];

  always #5 clk = ~clk;

  register_bank_sb #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_R0(1'b0)) dutA (
    .i_CLK(clk), .i_RSTn(rstn), .i_AddrReg1(addr1), .i_AddrReg2(addr2),
    .o_Data1(data1[0]), .o_Data2(data2[0]), .o_Busy1(busy1[0]), .o_Busy2(busy2[0]),
    .i_AddrRegDest(dest), .i_WriteData(wd), .i_WriteBack(wb), .i_Reserve(reserve),
    .i_AddrResv(resvA), .o_ResvAck(ack[0]), .o_PendCnt(pend[0]));

  register_bank_sb #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0), .ZERO_R0(1'b0)) dutB (
    .i_CLK(clk), .i_RSTn(rstn), .i_AddrReg1(addr1), .i_AddrReg2(addr2),
    .o_Data1(data1[1]), .o_Data2(data2[1]), .o_Busy1(busy1[1]), .o_Busy2(busy2[1]),
    .i_AddrRegDest(dest), .i_WriteData(wd), .i_WriteBack(wb), .i_Reserve(reserve),
    .i_AddrResv(resvA), .o_ResvAck(ack[1]), .o_PendCnt(pend[1]));

  register_bank_sb #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1), .ZERO_R0(1'b1)) dutZ (
    .i_CLK(clk), .i_RSTn(rstn), .i_AddrReg1(addr1), .i_AddrReg2(addr2),
    .o_Data1(data1[2]), .o_Data2(data2[2]), .o_Busy1(busy1[2]), .o_Busy2(busy2[2]),
    .i_AddrRegDest(dest), .i_WriteData(wd), .i_WriteBack(wb), .i_Reserve(reserve),
    .i_AddrResv(resvA), .o_ResvAck(ack[2]), .o_PendCnt(pend[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] expData(int c, logic [2:0] a);
    if (cfgZero[c] && a == 3'd0) return 8'h00;
    if (cfgByp[c] && wb && dest == a) return wd;
    return mReg[c][a];
  endfunction

  function automatic logic expBusy(int c, logic [2:0] a);
    if (cfgZero[c] && a == 3'd0) return 1'b0;
    if (cfgByp[c] && wb && dest == a) return 1'b0;
    return mBusy[c][a];
  endfunction

  function automatic logic expAck(int c);
    return reserve && (!mBusy[c][resvA] || (wb && dest == resvA));
  endfunction

  function automatic int expPend(int c);
    int n = 0;
    for (int r = 0; r < 8; r++) n += int'(mBusy[c][r]);
    return n;
  endfunction

  task automatic modelEdge();
    for (int c = 0; c < 3; c++) begin
      logic a;
      a = expAck(c);
      if (wb && !(cfgZero[c] && dest == 3'd0)) mReg[c][dest] = wd;
      if (wb) mBusy[c][dest] = 1'b0;
      if (a && !(cfgZero[c] && resvA == 3'd0)) mBusy[c][resvA] = 1'b1;
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      mBusy[c] = '0;
      for (int r = 0; r < 8; r++) mReg[c][r] = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) modelEdge();
    @(negedge clk);
  endtask

  task automatic doReset();
    wb = 1'b0; reserve = 1'b0;
    rstn = 1'b0;
    #3;
    @(negedge clk);
    rstn = 1'b1;
    modelReset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0; wd = 8'hFF; wb = 1'b1; dest = 3'd3;
    addr1 = 3'd3; addr2 = 3'd3; reserve = 1'b1; resvA = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (data1[c] !== 8'h00) begin failures++; $display("FAIL reset_data dut%0d: got %h want 00", c, data1[c]); end
      checks++; if (pend[c] !== 4'd0) begin failures++; $display("FAIL reset_pend dut%0d: got %0d want 0", c, pend[c]); end
      checks++; if (busy1[c] !== 1'b0) begin failures++; $display("FAIL reset_busy dut%0d: got %b want 0", c, busy1[c]); end
      checks++; if (ack[c] !== 1'b1) begin failures++; $display("FAIL reset_ack dut%0d: got %b want 1", c, ack[c]); end
    end
    reserve = 1'b0;
    rstn = 1'b1;
    modelReset();
    #1;
    checks++; if (data1[1] !== 8'h00) begin failures++; $display("FAIL reset_nowrite dutB: got %h want 00", data1[1]); end
    @(negedge clk);
    tick();
    wb = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (data1[c] !== 8'hFF) begin failures++; $display("FAIL reset_firstwrite dut%0d: got %h want ff", c, data1[c]); end
    end
  endtask

  task automatic test_write_bypass();
    doReset();
    wb = 1'b1; dest = 3'd3; wd = 8'hA5; addr1 = 3'd3; #1;
    for (int c = 0; c < 3; c++) begin
      logic [7:0] e;
      e = cfgByp[c] ? 8'hA5 : 8'h00;
      checks++; if (data1[c] !== e) begin failures++; $display("FAIL bypass_same dut%0d: got %h want %h", c, data1[c], e); end
    end
    tick();
    wb = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (data1[c] !== 8'hA5) begin failures++; $display("FAIL bypass_next dut%0d: got %h want a5", c, data1[c]); end
    end
  endtask

  task automatic test_reserve();
    doReset();
    reserve = 1'b1; resvA = 3'd5; addr1 = 3'd5; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ack[c] !== 1'b1) begin failures++; $display("FAIL resv_ack dut%0d: got %b want 1", c, ack[c]); end
    end
    tick(); #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ack[c] !== 1'b0) begin failures++; $display("FAIL resv_refuse dut%0d: got %b want 0", c, ack[c]); end
      checks++; if (busy1[c] !== 1'b1) begin failures++; $display("FAIL resv_busy dut%0d: got %b want 1", c, busy1[c]); end
      checks++; if (pend[c] !== 4'd1) begin failures++; $display("FAIL resv_pend dut%0d: got %0d want 1", c, pend[c]); end
    end
    tick(); #1;
    checks++; if (pend[0] !== 4'd1) begin failures++; $display("FAIL resv_hold_pend dutA: got %0d want 1", pend[0]); end
    reserve = 1'b0; wb = 1'b1; dest = 3'd5; wd = 8'h3C; #1;
    for (int c = 0; c < 3; c++) begin
      logic e;
      e = cfgByp[c] ? 1'b0 : 1'b1;
      checks++; if (busy1[c] !== e) begin failures++; $display("FAIL release_bypass dut%0d: got %b want %b", c, busy1[c], e); end
    end
    tick();
    wb = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (busy1[c] !== 1'b0) begin failures++; $display("FAIL release_busy dut%0d: got %b want 0", c, busy1[c]); end
      checks++; if (pend[c] !== 4'd0) begin failures++; $display("FAIL release_pend dut%0d: got %0d want 0", c, pend[c]); end
      checks++; if (data1[c] !== 8'h3C) begin failures++; $display("FAIL release_data dut%0d: got %h want 3c", c, data1[c]); end
    end
  endtask

  task automatic test_same_cycle();
    doReset();
    reserve = 1'b1; resvA = 3'd2; addr1 = 3'd2;
    tick();
    wb = 1'b1; dest = 3'd2; wd = 8'h11; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ack[c] !== 1'b1) begin failures++; $display("FAIL same_ack dut%0d: got %b want 1", c, ack[c]); end
    end
    tick();
    reserve = 1'b0; wb = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (busy1[c] !== 1'b1) begin failures++; $display("FAIL same_busy dut%0d: got %b want 1", c, busy1[c]); end
      checks++; if (data1[c] !== 8'h11) begin failures++; $display("FAIL same_data dut%0d: got %h want 11", c, data1[c]); end
      checks++; if (pend[c] !== 4'd1) begin failures++; $display("FAIL same_pend dut%0d: got %0d want 1", c, pend[c]); end
    end
  endtask

  task automatic test_zero_r0();
    doReset();
    wb = 1'b1; dest = 3'd0; wd = 8'h77; addr1 = 3'd0; #1;
    checks++; if (data1[2] !== 8'h00) begin failures++; $display("FAIL zero_bypass dutZ: got %h want 00", data1[2]); end
    tick();
    wb = 1'b0; #1;
    checks++; if (data1[2] !== 8'h00) begin failures++; $display("FAIL zero_write dutZ: got %h want 00", data1[2]); end
    checks++; if (data1[0] !== 8'h77) begin failures++; $display("FAIL zero_ctrl dutA: got %h want 77", data1[0]); end
    reserve = 1'b1; resvA = 3'd0; #1;
    checks++; if (ack[2] !== 1'b1) begin failures++; $display("FAIL zero_ack dutZ: got %b want 1", ack[2]); end
    tick();
    reserve = 1'b0; #1;
    checks++; if (busy1[2] !== 1'b0) begin failures++; $display("FAIL zero_busy dutZ: got %b want 0", busy1[2]); end
    checks++; if (pend[2] !== 4'd0) begin failures++; $display("FAIL zero_pend dutZ: got %0d want 0", pend[2]); end
    checks++; if (pend[0] !== 4'd1) begin failures++; $display("FAIL zero_ctrl_pend dutA: got %0d want 1", pend[0]); end
  endtask

  task automatic test_fill_and_async_reset();
    doReset();
    for (int r = 0; r < 8; r++) begin
      reserve = 1'b1; resvA = 3'(r);
      tick();
    end
    reserve = 1'b0; addr1 = 3'd5; #1;
    checks++; if (pend[0] !== 4'd8) begin failures++; $display("FAIL fill_pend dutA: got %0d want 8", pend[0]); end
    checks++; if (pend[1] !== 4'd8) begin failures++; $display("FAIL fill_pend dutB: got %0d want 8", pend[1]); end
    checks++; if (pend[2] !== 4'd7) begin failures++; $display("FAIL fill_pend dutZ: got %0d want 7", pend[2]); end
    checks++; if (busy1[0] !== 1'b1) begin failures++; $display("FAIL fill_busy dutA: got %b want 1", busy1[0]); end
    #2;
    rstn = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (pend[c] !== 4'd0) begin failures++; $display("FAIL async_pend dut%0d: got %0d want 0", c, pend[c]); end
      checks++; if (busy1[c] !== 1'b0) begin failures++; $display("FAIL async_busy dut%0d: got %b want 0", c, busy1[c]); end
    end
    modelReset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_random();
    doReset();
    repeat (400) begin
      addr1   = 3'($urandom_range(0, 7));
      addr2   = 3'($urandom_range(0, 7));
      dest    = 3'($urandom_range(0, 7));
      resvA   = 3'($urandom_range(0, 7));
      wd      = 8'($urandom);
      wb      = ($urandom_range(0, 2) == 0);
      reserve = ($urandom_range(0, 1) == 1);
      #1;
      for (int c = 0; c < 3; c++) begin
        checks++; if (data1[c] !== expData(c, addr1)) begin failures++; $display("FAIL rnd_data1 dut%0d: got %h want %h", c, data1[c], expData(c, addr1)); end
        checks++; if (data2[c] !== expData(c, addr2)) begin failures++; $display("FAIL rnd_data2 dut%0d: got %h want %h", c, data2[c], expData(c, addr2)); end
        checks++; if (busy1[c] !== expBusy(c, addr1)) begin failures++; $display("FAIL rnd_busy1 dut%0d: got %b want %b", c, busy1[c], expBusy(c, addr1)); end
        checks++; if (busy2[c] !== expBusy(c, addr2)) begin failures++; $display("FAIL rnd_busy2 dut%0d: got %b want %b", c, busy2[c], expBusy(c, addr2)); end
        checks++; if (ack[c] !== expAck(c)) begin failures++; $display("FAIL rnd_ack dut%0d: got %b want %b", c, ack[c], expAck(c)); end
        checks++; if (int'(pend[c]) != expPend(c)) begin failures++; $display("FAIL rnd_pend dut%0d: got %0d want %0d", c, pend[c], expPend(c)); end
      end
      tick();
    end
    wb = 1'b0; reserve = 1'b0;
  endtask

  initial begin
    cfgByp[0] = 1'b1; cfgByp[1] = 1'b0; cfgByp[2] = 1'b1;
    cfgZero[0] = 1'b0; cfgZero[1] = 1'b0; cfgZero[2] = 1'b1;
    rstn = 1'b0; wb = 1'b0; reserve = 1'b0; wd = '0;
    addr1 = '0; addr2 = '0; dest = '0; resvA = '0;
    modelReset();
    test_reset();
    test_write_bypass();
    test_reserve();
    test_same_cycle();
    test_zero_r0();
    test_fill_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
